// File: rtl/bip_report_tx.sv
// bip_report_tx
// Sits behind the BIP processor. It counts clock cycles from reset release
// until the CPU raises halt. When halt arrives it latches the accumulator and
// the cycle count, then sends them on tx as one 8N1 UART frame:
//   HEADER, acc[15:8], acc[7:0], count bytes MSB-first (CNT_WIDTH/8 of them)
// All bit timing comes from a shared 16x-oversampling baud tick (s_tick).
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-low reset
//   halt    in   CPU halt (level or pulse), sampled on clk
//   acc     in   CPU accumulator
//   s_tick  in   one-clk pulse at 16x baud
//   tx      out  serial line, idles high
//   busy    out  high while a frame is in flight
//   done    out  one-cycle pulse after the last stop bit
//   cycles  out  live cycle counter, frozen once halt is captured
//
// Top FSM
//   state  | meaning
//   RUN    | counting cycles, waiting for halt
//   SEND   | frame in flight, serializer sub-FSM active
//   FIN    | last stop bit finished, pulse done
//   HALTED | frame sent, idle until reset
//
// Serializer sub-FSM (only advances in SEND)
//   state     | meaning
//   SER_START | start bit (tx=0), 16 ticks
//   SER_DATA  | 8 data bits LSB first, 16 ticks each
//   SER_STOP  | stop bit (tx=1), SB_TICK ticks
//
// CNT_WIDTH must be a multiple of 8 and no larger than 16. DATA_WIDTH is
// fixed at 16 because the frame always carries two accumulator bytes.

module bip_report_tx #(
  parameter int         DATA_WIDTH = 16,
  parameter int         CNT_WIDTH  = 16,
  parameter int         SB_TICK    = 16,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic                  s_tick,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cycles
);

  localparam int                 NUM_BYTES = 3 + CNT_WIDTH / 8;
  localparam int                 FRAME_W   = 8 * NUM_BYTES;
  localparam logic [2:0]         LAST_BYTE = 3'(NUM_BYTES - 1);
  localparam logic [3:0]         SB_LAST   = 4'(SB_TICK - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, SEND, FIN, HALTED} top_state_t;
  typedef enum logic [1:0] {SER_START, SER_DATA, SER_STOP} ser_state_t;

  top_state_t             state;
  ser_state_t             ser;
  logic [3:0]             t;
  logic [2:0]             n;
  logic [7:0]             shreg;
  logic [2:0]             byte_idx;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic [FRAME_W-1:0]     frame;
  logic [2:0]             next_idx;
  logic [7:0]             next_byte;

  // Whole frame as one vector, byte 0 in the top bits. The header is a
  // constant, so only acc_q/cnt_q need to be latched.
  assign frame    = {HEADER, acc_q, cnt_q};
  assign next_idx = byte_idx + 3'd1;

  always_comb begin
    next_byte = HEADER;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (next_idx == 3'(i)) next_byte = frame[FRAME_W-8-8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      ser      <= SER_START;
      t        <= 4'd0;
      n        <= 3'd0;
      shreg    <= 8'd0;
      byte_idx <= 3'd0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cycles   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (halt) begin
            // Capture the count as it stood before this edge. The start
            // bit begins right away; the header needs no latching.
            acc_q    <= acc;
            cnt_q    <= cycles;
            busy     <= 1'b1;
            byte_idx <= 3'd0;
            shreg    <= HEADER;
            ser      <= SER_START;
            t        <= 4'd0;
            n        <= 3'd0;
            tx       <= 1'b0;
            state    <= SEND;
          end else if (cycles != CNT_MAX) begin
            cycles <= cycles + CNT_ONE;
          end
        end

        SEND: begin
          // The serializer only moves on a tick, so a missing s_tick
          // holds tx at its current level.
          if (s_tick) begin
            case (ser)
              SER_START: begin
                if (t == 4'd15) begin
                  t   <= 4'd0;
                  tx  <= shreg[0];
                  ser <= SER_DATA;
                end else begin
                  t <= t + 4'd1;
                end
              end

              SER_DATA: begin
                if (t == 4'd15) begin
                  t <= 4'd0;
                  if (n == 3'd7) begin
                    n   <= 3'd0;
                    tx  <= 1'b1;
                    ser <= SER_STOP;
                  end else begin
                    n     <= n + 3'd1;
                    shreg <= {1'b0, shreg[7:1]};
                    tx    <= shreg[1];
                  end
                end else begin
                  t <= t + 4'd1;
                end
              end

              SER_STOP: begin
                if (t == SB_LAST) begin
                  t <= 4'd0;
                  if (byte_idx == LAST_BYTE) begin
                    state <= FIN;
                  end else begin
                    // Next start bit follows the stop bit with no idle gap.
                    byte_idx <= next_idx;
                    shreg    <= next_byte;
                    tx       <= 1'b0;
                    ser      <= SER_START;
                  end
                end else begin
                  t <= t + 4'd1;
                end
              end

              default: ser <= SER_START;
            endcase
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          tx    <= 1'b1;
          state <= HALTED;
        end

        HALTED: begin
          tx <= 1'b1;
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_report_tx.sv
// Self-checking bench for bip_report_tx.
// Two instances: dut0 with the default 16-bit counter and dut8 with an 8-bit
// counter for the saturation case. A small UART receiver decodes whichever
// instance is selected by mon_sel, counting s_tick pulses to find mid-bits.

module tb_bip_report_tx;

  logic        clk = 1'b0;
  logic        reset, halt, rst8, halt8;
  logic        s_tick = 1'b0;
  logic        tick_en;
  logic [15:0] acc;
  logic [1:0]  div = 2'd0;

  logic        tx0, busy0, done0;
  logic [15:0] cycles0;
  logic        tx8, busy8, done8;
  logic [7:0]  cycles8;

  logic        mon_sel;
  logic        m_tx, m_busy, m_done;

  int checks   = 0;
  int failures = 0;

  // receiver / monitor state, written only by the receiver process
  logic        rx_clr;
  int          rx_st, rx_cnt, rx_ferr, done_cnt, tick_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_q [$];
  logic        busy_prev;

  always #5 clk = ~clk;

  // one-clk s_tick every 4 clocks, changed away from the active edge
  always @(negedge clk) begin
    div    = div + 2'd1;
    s_tick = tick_en && (div == 2'd0);
  end

  bip_report_tx dut0 (
    .clk(clk), .reset(reset), .halt(halt), .acc(acc), .s_tick(s_tick),
    .tx(tx0), .busy(busy0), .done(done0), .cycles(cycles0)
  );

  bip_report_tx #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .halt(halt8), .acc(acc), .s_tick(s_tick),
    .tx(tx8), .busy(busy8), .done(done8), .cycles(cycles8)
  );

  assign m_tx   = mon_sel ? tx8   : tx0;
  assign m_busy = mon_sel ? busy8 : busy0;
  assign m_done = mon_sel ? done8 : done0;

  // UART receiver: looks just after each rising edge. A start is seen when
  // tx drops while idle; ticks are then counted, data sampled at 8+16k.
  always begin
    @(posedge clk);
    #1;
    if (rx_clr) begin
      rx_st     = 0;
      rx_cnt    = 0;
      rx_ferr   = 0;
      done_cnt  = 0;
      tick_cnt  = 0;
      busy_prev = 1'b0;
      rx_sh     = 8'h00;
      rx_q.delete();
    end else begin
      if (m_done === 1'b1) done_cnt++;
      if (s_tick && busy_prev) tick_cnt++;
      if (rx_st == 0) begin
        if (m_tx === 1'b0) begin
          rx_st  = 1;
          rx_cnt = 0;
        end
      end else if (s_tick) begin
        rx_cnt++;
        if (rx_cnt == 8) begin
          if (m_tx !== 1'b0) rx_ferr++;
        end else if (rx_cnt == 152) begin
          if (m_tx !== 1'b1) rx_ferr++;
          rx_q.push_back(rx_sh);
          rx_st = 0;
        end else if (rx_cnt > 8 && ((rx_cnt - 8) % 16) == 0) begin
          rx_sh = {m_tx, rx_sh[7:1]};
        end
      end
      busy_prev = m_busy;
    end
  end

  // Reset dut0, clear the receiver, release reset and raise halt after
  // n_low clean edges (n_low=0: halt already high at release).
  task automatic begin_frame(input logic [15:0] a, input int n_low);
    @(negedge clk);
    reset  = 1'b0;
    halt   = 1'b0;
    rx_clr = 1'b1;
    acc    = a;
    repeat (2) @(negedge clk);
    rx_clr = 1'b0;
    if (n_low == 0) halt = 1'b1;
    reset = 1'b1;
    if (n_low > 0) begin
      repeat (n_low) @(negedge clk);
      halt = 1'b1;
    end
  endtask

  task automatic wait_done(input int limit, output bit timeout, output bit busy_gap);
    timeout  = 1'b1;
    busy_gap = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (m_busy !== 1'b1) busy_gap = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (cycles0 !== 16'h0000) begin failures++; $display("FAIL reset_cycles got=%h exp=0000", cycles0); end
    checks++; if (tx8 !== 1'b1) begin failures++; $display("FAIL reset_tx8 got=%b exp=1", tx8); end
    checks++; if (cycles8 !== 8'h00) begin failures++; $display("FAIL reset_cycles8 got=%h exp=00", cycles8); end
  endtask

  task automatic test_basic_frame;
    logic [7:0] exp [5] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h09};
    logic [7:0] got;
    bit to, gap;
    begin_frame(16'h1234, 9);
    @(negedge clk);
    checks++; if (cycles0 !== 16'd9) begin failures++; $display("FAIL basic_cycles got=%h exp=0009", cycles0); end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", busy0); end
    wait_done(5000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_done_timeout got=%b exp=0", to); end
    checks++; if (gap !== 1'b0) begin failures++; $display("FAIL basic_busy_gap got=%b exp=0", gap); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL basic_nbytes got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (rx_ferr != 0) begin failures++; $display("FAIL basic_framing got=%0d exp=0", rx_ferr); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (tick_cnt != 800) begin failures++; $display("FAIL basic_ticks got=%0d exp=800", tick_cnt); end
    checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL basic_tx_idle got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy0); end
    checks++; if (cycles0 !== 16'd9) begin failures++; $display("FAIL basic_cycles_frozen got=%h exp=0009", cycles0); end
  endtask

  task automatic test_corruption;
    logic [7:0] exp [5] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h09};
    logic [7:0] got;
    bit to, gap;
    begin_frame(16'h1234, 9);
    repeat (300) @(negedge clk);
    acc  = 16'hFFFF;
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_done(5000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL corrupt_done_timeout got=%b exp=0", to); end
    // halt pulse after the frame must not restart anything
    repeat (10) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (500) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL corrupt_nbytes got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL corrupt_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL corrupt_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL corrupt_busy got=%b exp=0", busy0); end
    checks++; if (cycles0 !== 16'd9) begin failures++; $display("FAIL corrupt_cycles got=%h exp=0009", cycles0); end
  endtask

  task automatic test_tick_stall;
    logic [7:0] exp [5] = '{8'hA5, 8'hBE, 8'hEF, 8'h00, 8'h09};
    logic [7:0] got;
    logic       stall_tx;
    bit         found, stable, to, gap;
    begin_frame(16'hBEEF, 9);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_q.size() == 1 && rx_st == 1 && rx_cnt >= 40) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL stall_reach_bit got=%b exp=1", found); end
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    stall_tx = m_tx;
    stable   = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (m_tx !== stall_tx) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL stall_tx_stable got=%b exp=1", stable); end
    tick_en = 1'b1;
    wait_done(6000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL stall_done_timeout got=%b exp=0", to); end
    checks++; if (gap !== 1'b0) begin failures++; $display("FAIL stall_busy_gap got=%b exp=0", gap); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL stall_nbytes got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (tick_cnt != 800) begin failures++; $display("FAIL stall_ticks got=%0d exp=800", tick_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp [5] = '{8'hA5, 8'h56, 8'h78, 8'h00, 8'h03};
    logic [7:0] got;
    bit found, to, gap;
    begin_frame(16'h1234, 9);
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rx_q.size() == 2 && rx_st == 1 && rx_cnt >= 20 && m_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL midrst_reach_byte2 got=%b exp=1", found); end
    reset = 1'b0;
    #1;
    checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
    checks++; if (cycles0 !== 16'h0000) begin failures++; $display("FAIL midrst_cycles got=%h exp=0000", cycles0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done0); end
    begin_frame(16'h5678, 3);
    wait_done(5000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_done_timeout got=%b exp=0", to); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL midrst_nbytes got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_immediate_halt;
    logic [7:0] exp [5] = '{8'hA5, 8'hCA, 8'hFE, 8'h00, 8'h00};
    logic [7:0] got;
    bit to, gap;
    begin_frame(16'hCAFE, 0);
    @(negedge clk);
    checks++; if (cycles0 !== 16'h0000) begin failures++; $display("FAIL imm_cycles got=%h exp=0000", cycles0); end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL imm_busy got=%b exp=1", busy0); end
    wait_done(5000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL imm_done_timeout got=%b exp=0", to); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL imm_nbytes got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL imm_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] exp [4] = '{8'hA5, 8'h13, 8'h57, 8'hFF};
    logic [7:0] got;
    bit to, gap;
    @(negedge clk);
    mon_sel = 1'b1;
    rx_clr  = 1'b1;
    acc     = 16'h1357;
    rst8    = 1'b0;
    halt8   = 1'b0;
    repeat (2) @(negedge clk);
    rx_clr = 1'b0;
    rst8   = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (cycles8 !== 8'd200) begin failures++; $display("FAIL sat_count200 got=%h exp=c8", cycles8); end
    repeat (100) @(negedge clk);
    checks++; if (cycles8 !== 8'hFF) begin failures++; $display("FAIL sat_count300 got=%h exp=ff", cycles8); end
    halt8 = 1'b1;
    @(negedge clk);
    halt8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL sat_busy got=%b exp=1", busy8); end
    wait_done(5000, to, gap);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL sat_done_timeout got=%b exp=0", to); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL sat_nbytes got=%0d exp=4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL sat_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (tick_cnt != 640) begin failures++; $display("FAIL sat_ticks got=%0d exp=640", tick_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sat_done_count got=%0d exp=1", done_cnt); end
    checks++; if (cycles8 !== 8'hFF) begin failures++; $display("FAIL sat_cycles_frozen got=%h exp=ff", cycles8); end
  endtask

  initial begin
    reset   = 1'b0;
    halt    = 1'b0;
    rst8    = 1'b0;
    halt8   = 1'b0;
    acc     = 16'h0000;
    tick_en = 1'b1;
    mon_sel = 1'b0;
    rx_clr  = 1'b1;

    test_reset;
    test_basic_frame;
    test_corruption;
    test_tick_stall;
    test_reset_mid_frame;
    test_immediate_halt;
    test_saturation;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bip_report_tx.md
Name: bip_report_tx

Overview:
- Downstream consumer of the BIP processor. Counts clock cycles from reset release until the CPU raises halt.
- On halt, latches the accumulator and the cycle count and serialises them as a 5-byte 8N1 UART frame on `tx`.
- Sits between the bip top-level outputs (`acc`, `halt`) and the board TX pin. Uses the shared 16x-oversampling baud tick.

Parameters:
- DATA_WIDTH, 16, accumulator width; fixed at 16 for this block.
- CNT_WIDTH, 16, cycle counter width; must be a multiple of 8 and at most 16.
- SB_TICK, 16, number of `s_tick` pulses in the stop bit.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- halt  input  1  CPU halt, level or pulse; sampled on `clk`.
- acc  input  DATA_WIDTH  CPU accumulator value.
- s_tick  input  1  one-`clk`-wide pulse at 16x the baud rate.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is being sent.
- done  output  1  single-cycle pulse when the stop bit of the last byte completes.
- cycles  output  CNT_WIDTH  live cycle counter; frozen once halt is captured.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=RUN, `cycles`=0, `tx`=1, `busy`=0, `done`=0.
  - All shift and tick counters cleared.
  - Reset mid-frame aborts the frame and forces `tx`=1 in the same instant, not at the next edge.
- Top FSM states: RUN -> SEND -> FIN -> HALTED.
- RUN:
  - `cycles` increments by 1 on each edge where `halt`=0.
  - Saturates at all-ones; no wrap.
  - On the first edge with `halt`=1: latch `acc` and `cycles` (the un-incremented value), set `busy`=1, byte index=0, go to SEND.
  - `halt` during the first edge after reset release: captured with `cycles`=0.
- SEND:
  - Bytes in order: HEADER, acc[15:8], acc[7:0], then the latched count MSB-first, CNT_WIDTH/8 bytes.
  - Default frame is 5 bytes.
  - `halt` and `acc` are ignored in this state.
- Serializer sub-FSM (START, DATA, STOP) with a 4-bit tick counter `t` and a 3-bit bit counter `n`:
  - START: `tx`=0. On an `s_tick` with `t`=15, set `t`=0 and go to DATA.
  - DATA: `tx`=current bit, LSB first. On an `s_tick` with `t`=15, shift; after bit 7, go to STOP.
  - STOP: `tx`=1. On an `s_tick` with `t`=SB_TICK-1: if more bytes remain, load the next byte and go to START (no idle gap); otherwise go to FIN.
  - `t` advances only on `s_tick`. With no ticks, `tx` holds its current level indefinitely.
- FIN: `done`=1 for exactly one cycle, `busy`=0, go to HALTED.
- HALTED:
  - `tx`=1, `cycles` frozen, `halt` ignored.
  - Only reset returns the block to RUN.
- Frame length: 5 bytes × (16 + 8×16 + SB_TICK) ticks = 800 `s_tick` pulses at defaults.
- Outputs are registered; `tx` changes on the `clk` edge that consumes the relevant `s_tick`.

Test Plan:
- Basic frame: release reset, `halt`=1 at the 10th edge, `acc`=16'h1234, `s_tick` every 4 clk.
  - Decoded bytes: A5 12 34 00 09.
  - `done` pulses once after 800 ticks; `busy` is high throughout; `tx` idles at 1 afterward.
- Corruption check: change `acc` to 16'hFFFF and pulse `halt` again during SEND.
  - Frame is still A5 12 34 00 09; no second frame is started.
- Saturation: CNT_WIDTH=8, hold `halt`=0 for 300 cycles, then halt.
  - `cycles`=8'hFF; frame is A5 xx xx FF (4 bytes, 640 ticks).
- Tick stall: stop `s_tick` mid-data-bit for 1000 clk.
  - `tx` is stable for the whole stall; the frame resumes correctly and decodes intact.
- Reset mid-frame: assert `reset`=0 during byte 2.
  - `tx`=1, `busy`=0, `cycles`=0 immediately.
  - After release, a new halt produces a full correct frame.
- Immediate halt: `halt`=1 already asserted when reset releases.
  - Frame is A5 acc_hi acc_lo 00 00.
